// File: rtl/sigma_accel_ctrl.sv
// CSR-mapped sequencer for the streaming accelerator: serialises software start requests,
// times each run, enforces a watchdog limit and raises a level interrupt on completion.
module sigma_accel_ctrl #(
    parameter logic [31:0] BASE_ADDR       = 32'h80000100,
    parameter logic [31:0] DEFAULT_TIMEOUT = 32'd1000000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        bus_req_i,
    input  logic        bus_we_i,
    input  logic [31:0] bus_addr_i,
    input  logic [3:0]  bus_be_i,
    input  logic [31:0] bus_wdata_i,
    output logic        bus_ack_o,
    output logic        bus_resp_o,
    output logic [31:0] bus_rdata_o,
    output logic        acc_on_o,
    output logic        acc_start_o,
    input  logic        acc_ready_i,
    input  logic        calc_fin_i,
    output logic        irq_o
);

    typedef enum logic [1:0] {
        S_OFF      = 2'd0,
        S_WAIT_RDY = 2'd1,
        S_IDLE     = 2'd2,
        S_RUN      = 2'd3
    } state_t;

    state_t      r_state;
    state_t      w_stateNext;
    logic        r_en;
    logic        r_irqEn;
    logic        r_pend;
    logic        r_done;
    logic        r_toFlag;
    logic        r_overrun;
    logic        r_irq;
    logic [31:0] r_cnt;
    logic [31:0] r_cycles;
    logic [31:0] r_timeout;
    logic        r_resp;
    logic [31:0] r_rdata;

    logic        w_sel;
    logic        w_rd;
    logic        w_wr;
    logic [3:0]  w_off;
    logic        w_wrCtrl;
    logic        w_wrStat;
    logic        w_wrTo;
    logic        w_en;
    logic        w_startReq;
    logic        w_ovSet;
    logic        w_busy;
    logic [31:0] w_cntNext;
    logic        w_toHit;
    logic        w_launch;
    logic        w_fin;
    logic        w_toEv;
    logic [31:0] w_rdVal;

    assign w_sel    = bus_req_i & (bus_addr_i[31:4] == BASE_ADDR[31:4]);
    assign w_rd     = w_sel & ~bus_we_i;
    assign w_wr     = w_sel & bus_we_i;
    assign w_off    = bus_addr_i[3:0];
    assign w_wrCtrl = w_wr & (w_off == 4'h0) & bus_be_i[0];
    assign w_wrStat = w_wr & (w_off == 4'h4) & bus_be_i[0];
    assign w_wrTo   = w_wr & (w_off == 4'hC);

    // A CTRL write takes effect on the FSM in the same cycle, so enable and abort act immediately.
    assign w_en       = w_wrCtrl ? bus_wdata_i[0] : r_en;
    assign w_startReq = w_wrCtrl & bus_wdata_i[1] & bus_wdata_i[0];
    assign w_ovSet    = w_startReq & (r_pend | (r_state == S_RUN));
    assign w_busy     = (r_state == S_RUN) | r_pend;

    assign w_cntNext = (r_cnt == 32'hFFFFFFFF) ? r_cnt : r_cnt + 32'd1;
    assign w_toHit   = (r_timeout != 32'd0) & (w_cntNext == r_timeout);

    always_comb begin
        w_stateNext = r_state;
        w_launch    = 1'b0;
        w_fin       = 1'b0;
        w_toEv      = 1'b0;
        case (r_state)
            S_OFF: begin
                if (w_en) w_stateNext = S_WAIT_RDY;
            end
            S_WAIT_RDY: begin
                if (!w_en)            w_stateNext = S_OFF;
                else if (acc_ready_i) w_stateNext = S_IDLE;
            end
            S_IDLE: begin
                if (!w_en) begin
                    w_stateNext = S_OFF;
                end else if (r_pend) begin
                    w_stateNext = S_RUN;
                    w_launch    = 1'b1;
                end
            end
            S_RUN: begin
                if (!w_en) begin
                    w_stateNext = S_OFF;
                end else if (calc_fin_i) begin
                    w_fin       = 1'b1;
                    w_stateNext = S_IDLE;
                end else if (w_toHit) begin
                    w_toEv      = 1'b1;
                    w_stateNext = S_IDLE;
                end
            end
            default: w_stateNext = S_OFF;
        endcase
    end

    always_comb begin
        w_rdVal = 32'd0;
        case (w_off)
            4'h0:    w_rdVal = {29'd0, r_irqEn, 1'b0, r_en};
            4'h4:    w_rdVal = {24'd0, 1'b0, r_state, acc_ready_i, r_overrun, r_toFlag, r_done, w_busy};
            4'h8:    w_rdVal = r_cycles;
            4'hC:    w_rdVal = r_timeout;
            default: w_rdVal = 32'd0;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state   <= S_OFF;
            r_en      <= 1'b0;
            r_irqEn   <= 1'b0;
            r_pend    <= 1'b0;
            r_done    <= 1'b0;
            r_toFlag  <= 1'b0;
            r_overrun <= 1'b0;
            r_irq     <= 1'b0;
            r_cnt     <= 32'd0;
            r_cycles  <= 32'd0;
            r_timeout <= DEFAULT_TIMEOUT;
            r_resp    <= 1'b0;
            r_rdata   <= 32'd0;
        end else begin
            r_state <= w_stateNext;
            if (w_wrCtrl) begin
                r_en    <= bus_wdata_i[0];
                r_irqEn <= bus_wdata_i[2];
            end
            if (!w_en || w_launch)
                r_pend <= 1'b0;
            else if (w_startReq && !w_ovSet)
                r_pend <= 1'b1;
            if (w_launch)
                r_cnt <= 32'd0;
            else if (r_state == S_RUN)
                r_cnt <= w_cntNext;
            if (w_fin || w_toEv)
                r_cycles <= w_cntNext;
            // Hardware set is ORed in after the W1C mask so a coincident set survives.
            r_done    <= (r_done    & ~(w_wrStat & bus_wdata_i[1])) | w_fin;
            r_toFlag  <= (r_toFlag  & ~(w_wrStat & bus_wdata_i[2])) | w_toEv;
            r_overrun <= (r_overrun & ~(w_wrStat & bus_wdata_i[3])) | w_ovSet;
            for (int i = 0; i < 4; i++) begin
                if (w_wrTo && bus_be_i[i])
                    r_timeout[8*i +: 8] <= bus_wdata_i[8*i +: 8];
            end
            r_irq   <= r_irqEn & (r_done | r_toFlag);
            r_resp  <= w_rd;
            r_rdata <= w_rd ? w_rdVal : 32'd0;
        end
    end

    assign bus_ack_o   = w_sel;
    assign bus_resp_o  = r_resp & ~rst_i;
    assign bus_rdata_o = rst_i ? 32'd0 : r_rdata;
    assign acc_on_o    = (r_state != S_OFF) & ~rst_i;
    assign acc_start_o = w_launch & ~rst_i;
    assign irq_o       = r_irq & ~rst_i;

endmodule

// File: tb/tb_sigma_accel_ctrl.sv
// Directed and randomized bench for sigma_accel_ctrl, checked against a register-level model
// that predicts run outcomes from the fin/timeout rules with plain arithmetic.
module tb_sigma_accel_ctrl;

    localparam logic [31:0] BASE = 32'h80000100;
    localparam logic [31:0] A_CTRL = BASE + 32'h0;
    localparam logic [31:0] A_STAT = BASE + 32'h4;
    localparam logic [31:0] A_CYC  = BASE + 32'h8;
    localparam logic [31:0] A_TO   = BASE + 32'hC;

    logic        clk = 1'b0;
    logic        rst;
    logic        req, we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        ack, resp;
    logic [31:0] rdata;
    logic        accOn, accStart, accReady, calcFin, irq;

    int testsRun = 0;
    int failCount = 0;
    int startCount = 0;

    logic [31:0] mTimeout;
    logic [31:0] mCycles;
    bit          mDone, mTo, mOvr;

    sigma_accel_ctrl dut (
        .clk_i(clk), .rst_i(rst),
        .bus_req_i(req), .bus_we_i(we), .bus_addr_i(addr), .bus_be_i(be), .bus_wdata_i(wdata),
        .bus_ack_o(ack), .bus_resp_o(resp), .bus_rdata_o(rdata),
        .acc_on_o(accOn), .acc_start_o(accStart), .acc_ready_i(accReady),
        .calc_fin_i(calcFin), .irq_o(irq)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (accStart) startCount++;

    initial begin
        #300000;
        $display("[TB] FAIL globalTimeout: simulation did not finish in time");
        $fatal(1, "[TB] time limit expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        testsRun++;
        assert (obs === exp) else begin
            failCount++;
            $error("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] statusWord(input logic [2:0] st, input bit busy, input bit rdy);
        return {24'd0, st, rdy, mOvr, mTo, mDone, busy};
    endfunction

    task automatic busWrite(input logic [31:0] a, input logic [3:0] b, input logic [31:0] d);
        req = 1'b1; we = 1'b1; addr = a; be = b; wdata = d;
        tick();
        req = 1'b0; we = 1'b0; be = 4'd0; wdata = 32'd0;
    endtask

    task automatic busRead(input string tag, input logic [31:0] a, input logic [31:0] exp);
        req = 1'b1; we = 1'b0; addr = a; be = 4'hF;
        @(negedge clk);
        checkOutput({tag, "/ack"}, ack, 1);
        tick();
        req = 1'b0;
        checkOutput({tag, "/resp"}, resp, 1);
        checkOutput({tag, "/data"}, rdata, exp);
        tick();
        checkOutput({tag, "/respLow"}, resp, 0);
    endtask

    task automatic busNoAck(input string tag, input logic [31:0] a);
        req = 1'b1; we = 1'b0; addr = a; be = 4'hF;
        @(negedge clk);
        checkOutput({tag, "/ack"}, ack, 0);
        tick();
        req = 1'b0;
        checkOutput({tag, "/resp"}, resp, 0);
    endtask

    // Returns in the slot of the first RUN cycle.
    task automatic waitStart(input string tag);
        bit found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk);
            if (accStart) found = 1;
        end
        checkOutput({tag, "/startSeen"}, found, 1);
        tick();
    endtask

    // Drives calc_fin for one cycle on RUN cycle fin (0 = never) over len cycles.
    task automatic applyStimulus(input int fin, input int len);
        for (int c = 1; c <= len; c++) begin
            calcFin = (c == fin);
            tick();
        end
        calcFin = 1'b0;
    endtask

    task automatic clearSticky();
        busWrite(A_STAT, 4'h1, 32'hE);
        mDone = 0; mTo = 0; mOvr = 0;
    endtask

    task automatic runCase(input string tag, input int t, input int fin);
        int s0;
        clearSticky();
        busWrite(A_TO, 4'hF, t);
        mTimeout = t;
        s0 = startCount;
        busWrite(A_CTRL, 4'h1, 32'h7);
        waitStart(tag);
        applyStimulus(fin, 16);
        if (fin != 0 && (t == 0 || fin <= t)) begin
            mDone = 1; mCycles = fin;
        end else begin
            mTo = 1; mCycles = t;
        end
        busRead({tag, "/cycles"}, A_CYC, mCycles);
        busRead({tag, "/status"}, A_STAT, statusWord(3'd2, 0, 1));
        checkOutput({tag, "/pulses"}, startCount - s0, 1);
    endtask

    initial begin
        int s0;
        int t, fin;
        logic [31:0] v, d;
        logic [3:0]  b;

        rst = 1'b1; req = 0; we = 0; addr = 0; be = 0; wdata = 0;
        accReady = 0; calcFin = 0;
        mTimeout = 32'd1000000; mCycles = 0; mDone = 0; mTo = 0; mOvr = 0;
        tick();
        tick();
        @(negedge clk);
        checkOutput("reset/accOn", accOn, 0);
        checkOutput("reset/accStart", accStart, 0);
        checkOutput("reset/irq", irq, 0);
        checkOutput("reset/resp", resp, 0);
        tick();
        rst = 1'b0;

        busRead("reset/timeout", A_TO, 32'd1000000);
        busRead("reset/status", A_STAT, 32'h0);
        busRead("reset/cycles", A_CYC, 32'h0);
        checkOutput("pwr/offBeforeEn", accOn, 0);

        // Power-up handshake
        busWrite(A_CTRL, 4'h1, 32'h1);
        checkOutput("pwr/accOn", accOn, 1);
        busRead("pwr/statusWait", A_STAT, statusWord(3'd1, 0, 0));
        tick();
        accReady = 1'b1;
        tick();
        tick();
        busRead("pwr/statusIdle", A_STAT, statusWord(3'd2, 0, 1));
        checkOutput("pwr/noStart", startCount, 0);

        // Normal run ending on the 10th RUN cycle
        s0 = startCount;
        busWrite(A_CTRL, 4'h1, 32'h7);
        waitStart("run10");
        applyStimulus(10, 10);
        mDone = 1; mCycles = 10;
        checkOutput("run10/irqLatency", irq, 0);
        tick();
        checkOutput("run10/irq", irq, 1);
        busRead("run10/cycles", A_CYC, 32'd10);
        busRead("run10/status", A_STAT, statusWord(3'd2, 0, 1));
        checkOutput("run10/pulses", startCount - s0, 1);
        busWrite(A_STAT, 4'h1, 32'h2);
        mDone = 0;
        tick();
        checkOutput("run10/irqCleared", irq, 0);

        // Watchdog, fin on the limit cycle, then random mixes
        runCase("wdog4", 4, 0);
        runCase("fin4", 4, 4);
        for (int i = 0; i < 6; i++) begin
            t = $urandom_range(0, 12);
            fin = $urandom_range((t == 0) ? 1 : 0, 15);
            runCase($sformatf("rand%0d", i), t, fin);
        end

        // Overrun while running
        clearSticky();
        busWrite(A_TO, 4'hF, 32'd0);
        mTimeout = 0;
        s0 = startCount;
        busWrite(A_CTRL, 4'h1, 32'h7);
        waitStart("ovr");
        busWrite(A_CTRL, 4'h1, 32'h7);
        mOvr = 1;
        applyStimulus(3, 3);
        mDone = 1; mCycles = 4;
        tick();
        checkOutput("ovr/pulses", startCount - s0, 1);
        busRead("ovr/status", A_STAT, statusWord(3'd2, 0, 1));
        busRead("ovr/cycles", A_CYC, 32'd4);

        // Start queued in WAIT_RDY
        clearSticky();
        accReady = 1'b0;
        busWrite(A_CTRL, 4'h1, 32'h0);
        busWrite(A_CTRL, 4'h1, 32'h1);
        s0 = startCount;
        busWrite(A_CTRL, 4'h1, 32'h7);
        busRead("queue/status", A_STAT, statusWord(3'd1, 1, 0));
        checkOutput("queue/noEarlyStart", startCount - s0, 0);
        accReady = 1'b1;
        tick();
        @(negedge clk);
        checkOutput("queue/startOnIdle", accStart, 1);
        tick();
        applyStimulus(2, 2);
        mDone = 1; mCycles = 2;
        checkOutput("queue/pulses", startCount - s0, 1);
        busRead("queue/cycles", A_CYC, 32'd2);

        // Abort on the 3rd RUN cycle
        clearSticky();
        s0 = startCount;
        busWrite(A_CTRL, 4'h1, 32'h7);
        waitStart("abort");
        tick();
        tick();
        busWrite(A_CTRL, 4'h1, 32'h0);
        checkOutput("abort/accOn", accOn, 0);
        calcFin = 1'b1;
        tick();
        calcFin = 1'b0;
        busRead("abort/cycles", A_CYC, mCycles);
        busRead("abort/status", A_STAT, statusWord(3'd0, 0, 1));
        checkOutput("abort/pulses", startCount - s0, 1);

        // Bus decode and byte lanes
        busWrite(A_CTRL, 4'h1, 32'h5);
        tick();
        tick();
        busRead("bus/ctrl", A_CTRL, 32'h5);
        busWrite(A_CTRL, 4'hE, 32'h0);
        busRead("bus/ctrlLane0Only", A_CTRL, 32'h5);
        busRead("bus/undef", BASE + 32'h1, 32'h0);
        busNoAck("bus/off10", BASE + 32'h10);
        busNoAck("bus/lowAddr", 32'h00000100);
        v = $urandom;
        if (v[31:4] == BASE[31:4]) v[31] = ~v[31];
        busNoAck("bus/randAddr", v);
        v = $urandom;
        busWrite(A_TO, 4'hF, v);
        mTimeout = v;
        busWrite(A_TO, 4'b0010, 32'h0000AB00);
        mTimeout = {v[31:16], 8'hAB, v[7:0]};
        busRead("bus/toByte1", A_TO, mTimeout);
        for (int i = 0; i < 4; i++) begin
            b = 4'($urandom_range(0, 15));
            d = $urandom;
            busWrite(A_TO, b, d);
            for (int l = 0; l < 4; l++)
                if (b[l]) mTimeout[8*l +: 8] = d[8*l +: 8];
            busRead($sformatf("bus/toLanes%0d", i), A_TO, mTimeout);
        end
        busWrite(A_CYC, 4'hF, $urandom);
        busRead("bus/cyclesRO", A_CYC, mCycles);

        // Reset in the middle of a run, with a read accepted in the reset cycle
        busWrite(A_TO, 4'hF, 32'd0);
        busWrite(A_CTRL, 4'h1, 32'h7);
        waitStart("rstRun");
        s0 = startCount;
        tick();
        rst = 1'b1;
        req = 1'b1; we = 1'b0; addr = A_STAT; be = 4'hF;
        @(negedge clk);
        checkOutput("rstRun/accStart", accStart, 0);
        checkOutput("rstRun/accOn", accOn, 0);
        tick();
        rst = 1'b0;
        req = 1'b0;
        checkOutput("rstRun/noResp", resp, 0);
        checkOutput("rstRun/off", accOn, 0);
        mDone = 0; mTo = 0; mOvr = 0; mCycles = 0; mTimeout = 32'd1000000;
        busRead("rstRun/timeout", A_TO, mTimeout);
        busRead("rstRun/status", A_STAT, statusWord(3'd0, 0, 1));
        busRead("rstRun/cycles", A_CYC, mCycles);
        checkOutput("rstRun/noGlitch", startCount - s0, 0);

        $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
        $finish;
    end

endmodule
